// File: rtl/row_streamer.sv
// Row FIFO plus LSB-first beat serialiser with per-image done pulse and synchronous abort.
// Optional `level` occupancy port is enabled by defining ROW_STREAMER_LEVEL_EN.
module row_streamer #(
  parameter int unsigned ROW_W        = 480,
  parameter int unsigned BEAT_W       = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ROWS_PER_IMG = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              row_valid,
  output logic              row_ready,
  output logic [BEAT_W-1:0] beat_out,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic              beat_last,
  output logic              done
`ifdef ROW_STREAMER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned BEATS = ROW_W / BEAT_W;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RCW   = (ROWS_PER_IMG > 1) ? $clog2(ROWS_PER_IMG) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [RCW-1:0] LAST_ROW  = RCW'(ROWS_PER_IMG - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e            state_q;
  logic [ROW_W-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ROW_W-1:0]  shift_q;
  logic [BCW-1:0]    beat_cnt_q;
  logic [RCW-1:0]    row_cnt_q;
  logic              valid_q, last_q, done_q;
  logic              empty_c, full_c, push_c, hs_c, pop_c;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign row_ready = !full_c && rst;
  assign push_c    = row_valid && row_ready && !interrupt;
  assign hs_c      = valid_q && beat_ready;
  assign pop_c     = !interrupt && !empty_c && ((state_q == IDLE) || (hs_c && last_q));

  assign beat_out   = shift_q[BEAT_W-1:0];
  assign beat_valid = valid_q;
  assign beat_last  = last_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= row_in;
  end

  // Control FSM, pointers, counters; interrupt flushes everything except storage.
  always_ff @(posedge clk) begin
    if (!rst || interrupt) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);

      if (pop_c) begin
        shift_q    <= mem_q[rd_ptr_q[AW-1:0]];
        beat_cnt_q <= '0;
        state_q    <= STREAM;
        valid_q    <= 1'b1;
        last_q     <= (BEATS == 1);
      end else if (hs_c) begin
        shift_q    <= shift_q >> BEAT_W;
        beat_cnt_q <= beat_cnt_q + BCW'(1);
        if (last_q) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          last_q  <= (beat_cnt_q == LAST_BEAT - BCW'(1));
        end
      end

      if (hs_c && last_q) begin
        if (row_cnt_q == LAST_ROW) begin
          row_cnt_q <= '0;
          done_q    <= 1'b1;
        end else begin
          row_cnt_q <= row_cnt_q + RCW'(1);
        end
      end
    end
  end

`ifdef ROW_STREAMER_LEVEL_EN
  logic [PW-1:0] level_q;

  always_ff @(posedge clk) begin
    if (!rst || interrupt) begin
      level_q <= '0;
    end else if (push_c && !pop_c) begin
      level_q <= level_q + PW'(1);
    end else if (pop_c && !push_c) begin
      level_q <= level_q - PW'(1);
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_row_streamer.sv
// Directed bench for row_streamer: latency, streaming order, backpressure, done pulses, abort.
module tb_row_streamer;

  localparam int ROW_W = 480;
  localparam int BEAT_W = 16;
  localparam int BEATS = 30;
  localparam int ROWS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              interrupt = 1'b0;
  logic [ROW_W-1:0]  row_in = '0;
  logic              row_valid = 1'b0;
  logic              row_ready;
  logic [BEAT_W-1:0] beat_out;
  logic              beat_valid;
  logic              beat_ready = 1'b0;
  logic              beat_last;
  logic              done;
  logic [2:0]        level;

  int n_cmp = 0;
  int n_err = 0;
  logic [ROW_W-1:0] exp_rows [8];

  row_streamer #(
    .ROW_W(ROW_W), .BEAT_W(BEAT_W), .DEPTH(4), .ROWS_PER_IMG(ROWS)
  ) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .beat_out(beat_out), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_last(beat_last), .done(done)
`ifdef ROW_STREAMER_LEVEL_EN
    , .level(level)
`endif
  );

`ifndef ROW_STREAMER_LEVEL_EN
  assign level = 3'd0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int r);
    logic [ROW_W-1:0] v;
    for (int k = 0; k < BEATS; k++) v[k*BEAT_W +: BEAT_W] = 16'((r << 8) | k);
    return v;
  endfunction

  task automatic flush();
    row_valid = 1'b0;
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    check("flush_valid", 32'(beat_valid), 32'd0);
    check("flush_ready", 32'(row_ready), 32'd1);
`ifdef ROW_STREAMER_LEVEL_EN
    check("flush_level", 32'(level), 32'd0);
`endif
  endtask

  task automatic push_rows(input int base, input int n);
    row_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      row_in = mk_row(base + i);
      exp_rows[i] = row_in;
      check("push_ready", 32'(row_ready), 32'd1);
      step();
    end
    row_valid = 1'b0;
  endtask

  // Streams nrows of exp_rows with beat_ready high; checks data, last and done every cycle.
  task automatic stream(input int nrows, input int start_rows, output int span);
    int hs = 0;
    int first = -1;
    int cyc = 0;
    int rows_model = start_rows;
    logic exp_done = 1'b0;
    logic [ROW_W-1:0] cur;
    beat_ready = 1'b1;
    while (hs < nrows * BEATS && cyc < 1000) begin
      check("done", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
      if (beat_valid) begin
        if (first < 0) first = cyc;
        cur = exp_rows[hs / BEATS];
        check("beat_out", 32'(beat_out), 32'(cur[(hs % BEATS)*BEAT_W +: BEAT_W]));
        check("beat_last", 32'(beat_last), 32'((hs % BEATS) == BEATS - 1));
        hs++;
        if (hs % BEATS == 0) begin
          rows_model++;
          if (rows_model == ROWS) begin
            exp_done = 1'b1;
            rows_model = 0;
          end
        end
      end
      step();
      cyc++;
    end
    check("stream_beats", 32'(hs), 32'(nrows * BEATS));
    check("done_final", 32'(done), 32'(exp_done));
    span = cyc - first;
  endtask

  initial begin
    logic [ROW_W-1:0] tmp;
    int span;
    int acc;

    // Reset values
    repeat (3) step();
    check("rst_ready", 32'(row_ready), 32'd0);
    check("rst_valid", 32'(beat_valid), 32'd0);
    check("rst_last", 32'(beat_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_beat", 32'(beat_out), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_ready", 32'(row_ready), 32'd1);

    // Latency: first beat two edges after acceptance
    tmp = mk_row(0);
    tmp[15:0] = 16'h1234;
    tmp[479:464] = 16'hABCD;
    exp_rows[0] = tmp;
    row_in = tmp;
    row_valid = 1'b1;
    beat_ready = 1'b1;
    step();
    row_valid = 1'b0;
    check("lat_not_yet", 32'(beat_valid), 32'd0);
    step();
    check("lat_valid", 32'(beat_valid), 32'd1);
    check("lat_first", 32'(beat_out), 32'h1234);
    stream(1, 0, span);
    check("lat_idle", 32'(beat_valid), 32'd0);
    flush();

    // Back-to-back: 3 rows, 90 consecutive beats
    beat_ready = 1'b0;
    push_rows(1, 3);
    stream(3, 0, span);
    check("b2b_span", 32'(span), 32'd90);
    check("b2b_idle", 32'(beat_valid), 32'd0);
    flush();

    // Backpressure/full: 5 rows accepted, head held stable
    beat_ready = 1'b0;
    acc = 0;
    row_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!row_ready) break;
      row_in = mk_row(10 + acc);
      step();
      acc++;
    end
    row_valid = 1'b0;
    tmp = mk_row(10);
    check("full_accepted", 32'(acc), 32'd5);
    check("full_ready", 32'(row_ready), 32'd0);
    check("full_valid", 32'(beat_valid), 32'd1);
`ifdef ROW_STREAMER_LEVEL_EN
    check("full_level", 32'(level), 32'd4);
`endif
    repeat (3) step();
    check("stall_beat", 32'(beat_out), 32'(tmp[15:0]));
    check("stall_last", 32'(beat_last), 32'd0);
    beat_ready = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      check("drain_ready", 32'(row_ready), 32'd0);
      check("drain_beat", 32'(beat_out), 32'(tmp[k*BEAT_W +: BEAT_W]));
      step();
    end
    check("head_freed", 32'(row_ready), 32'd1);
    for (int r = 0; r < 4; r++) exp_rows[r] = mk_row(11 + r);
    stream(4, 1, span);
    flush();

    // Image done: 4 rows, done after beats 60 and 120
    beat_ready = 1'b0;
    push_rows(40, 4);
    stream(4, 0, span);
    check("img_span", 32'(span), 32'd120);
    repeat (3) begin
      step();
      check("img_no_done", 32'(done), 32'd0);
    end
    flush();

    // Abort mid-row with rows queued; offered row during abort is dropped
    beat_ready = 1'b0;
    push_rows(20, 3);
    beat_ready = 1'b1;
    repeat (40) step();
    tmp = mk_row(21);
    check("abort_pre_beat", 32'(beat_out), 32'(tmp[10*BEAT_W +: BEAT_W]));
    interrupt = 1'b1;
    row_valid = 1'b1;
    row_in = mk_row(99);
    step();
    interrupt = 1'b0;
    row_valid = 1'b0;
    check("abort_valid", 32'(beat_valid), 32'd0);
    check("abort_ready", 32'(row_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    repeat (2) step();
    check("abort_dropped", 32'(beat_valid), 32'd0);
    beat_ready = 1'b0;
    push_rows(30, 2);
    stream(2, 0, span);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_streamer.md
# row_streamer

Parametrised row buffer and beat serialiser between the host-side row loader and the CNN accelerator input. It accepts whole feature-map rows of ROW_W bits into a DEPTH-row FIFO, then streams each row as ROW_W/BEAT_W beats over a valid/ready interface. It counts rows per image and pulses `done` after the last beat of each image. It supports a synchronous abort driven by `interrupt`.

## Interface
Parameters:
- ROW_W, 480: row width in bits; must be a multiple of BEAT_W.
- BEAT_W, 16: output beat width in bits.
- DEPTH, 4: row FIFO depth; must be a power of 2 and at least 2.
- ROWS_PER_IMG, 28: rows per image; must be at least 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- interrupt  in  1  synchronous abort/flush, active high.
- row_in  in  ROW_W  row data.
- row_valid  in  1  row_in is valid.
- row_ready  out  1  FIFO can accept a row.
- beat_out  out  BEAT_W  current beat.
- beat_valid  out  1  beat_out is valid.
- beat_ready  in  1  downstream accepts the beat.
- beat_last  out  1  beat_out is the final beat of the row.
- done  out  1  one-cycle pulse at the end of an image.
- level  out  clog2(DEPTH)+1  FIFO occupancy; present only with ROW_STREAMER_LEVEL_EN.

## Operation
- Derived values:
  - BEATS = ROW_W/BEAT_W.
  - Beat counter is clog2(BEATS) bits wide.
  - Row counter is clog2(ROWS_PER_IMG) bits wide, minimum 1 bit.
- Push side:
  - A row is written when row_valid && row_ready.
  - row_ready = !full && rst, so it reads 0 while reset is held.
  - There is no write-through when the FIFO is full: row_ready stays low even if a pop occurs in the same cycle.
- FSM states: IDLE, STREAM.
  - IDLE: if the FIFO is non-empty, pop the head row into the shift register, clear the beat counter, and go to STREAM.
  - STREAM:
    - beat_valid = 1.
    - beat_out = shift_reg[BEAT_W-1:0]. Beat order is LSB-first, so beat k = row[k*BEAT_W +: BEAT_W].
    - On a handshake (beat_valid && beat_ready), shift right by BEAT_W and increment the beat counter.
    - beat_last = 1 when the beat counter equals BEATS-1.
    - On a handshake with beat_last: if the FIFO is non-empty, pop and load the next row in the same cycle and stay in STREAM (no bubble); otherwise go to IDLE.
- beat_out, beat_last, and the shift register hold stable while beat_valid && !beat_ready.
- Row counter:
  - Increments on every handshake with beat_last.
  - When that handshake completes row ROWS_PER_IMG-1, `done` = 1 in the next cycle and the counter wraps to 0.
- interrupt has priority over all other activity:
  - FIFO pointers cleared.
  - Current row discarded.
  - Beat and row counters cleared.
  - State goes to IDLE.
  - No `done` is generated.
  - A row offered in the same cycle is not stored.
- Reset has priority over interrupt.

## Timing
- Reset values:
  - beat_valid=0, beat_last=0, done=0, beat_out=0.
  - FIFO empty, so level=0.
  - State IDLE, all counters 0.
  - row_ready=0 during reset and 1 in the first cycle after reset.
- Latency: a row accepted at edge t with the block idle and the FIFO empty gives beat_valid=1 in the cycle after edge t+1, i.e. 2 edges of latency.
- Throughput: 1 beat per cycle with beat_ready held high, back-to-back across rows.
- Full FIFO: DEPTH rows are held in the FIFO, plus 1 row in the shift register.
- done: registered; high exactly one cycle after the final handshake of an image.
- interrupt asserted at edge t: beat_valid=0, level=0, and row_ready=1 in the cycle after t.

## Configuration
- ROW_STREAMER_LEVEL_EN:
  - Defined: the `level` port exists and is a registered FIFO occupancy (0..DEPTH), updated on the same edge as push/pop.
  - Undefined: the `level` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset/latency: ROW_W=480, BEAT_W=16. Release reset and push row with bits [15:0]=0x1234 and [479:464]=0xABCD -> first beat_out=0x1234 2 cycles later; 30th beat = 0xABCD with beat_last=1; beat_valid=0 afterwards.
- Back-to-back: push 3 rows with beat_ready=1 -> 90 consecutive beat_valid cycles; beat_last at beats 30, 60, and 90.
- Backpressure/full: DEPTH=4 with beat_ready=0. Push until stall -> 5 rows accepted (4 in the FIFO, 1 in the shift register), row_ready=0, beat_out stable. Raise beat_ready -> row_ready=1 after the first row drains from the FIFO head.
- Image done: ROWS_PER_IMG=2, push 4 rows -> done pulses 1 cycle after beat 60 and again after beat 120; never otherwise.
- Abort: assert interrupt mid-row (beat 10) with 2 rows queued -> next cycle beat_valid=0 and level=0. A new row then streams from beat 0, and done arrives only after ROWS_PER_IMG fresh rows.
